// File: rtl/bp_fe_fence_sequencer_pkg.sv
// Shared types for the FE fence sequencer.
// State encoding and the post-drain routing helper.
package bp_fe_pkg;

    typedef enum logic [2:0] {
        e_fence_idle,
        e_fence_drain,
        e_fence_flush,
        e_fence_req,
        e_fence_wait,
        e_fence_resume
    } bp_fe_fence_state_e;

    // Where to go once the I$ fill credits have drained
    function automatic bp_fe_fence_state_e fence_after_drain(
        input logic itlb,
        input logic icache
    );
        if (itlb) begin
            return e_fence_flush;
        end else if (icache) begin
            return e_fence_req;
        end
        return e_fence_resume;
    endfunction

endpackage

// File: rtl/bp_fe_fence_sequencer_if.sv
// Command, I$, IMMU and pc_gen handshakes of the fence sequencer.
// slave = sequencer side, master = surrounding FE datapath.
interface bp_fe_fence_sequencer_if #(
    parameter int vaddr_width_p = 39
) ();
    logic                     fence_v_i;
    logic                     fence_itlb_i;
    logic                     fence_icache_i;
    logic [vaddr_width_p-1:0] fence_npc_i;
    logic                     fence_yumi_o;
    logic                     credits_empty_i;
    logic                     itlb_flush_v_o;
    logic                     icache_fence_v_o;
    logic                     icache_fence_yumi_i;
    logic                     icache_fence_done_i;
    logic                     redirect_v_o;
    logic [vaddr_width_p-1:0] redirect_pc_o;
    logic                     redirect_yumi_i;
    logic                     fetch_block_o;
    logic                     busy_o;
    logic                     timeout_o;

    modport slave (
        input  fence_v_i, fence_itlb_i, fence_icache_i, fence_npc_i,
        input  credits_empty_i, icache_fence_yumi_i, icache_fence_done_i,
        input  redirect_yumi_i,
        output fence_yumi_o, itlb_flush_v_o, icache_fence_v_o,
        output redirect_v_o, redirect_pc_o, fetch_block_o, busy_o, timeout_o
    );

    modport master (
        output fence_v_i, fence_itlb_i, fence_icache_i, fence_npc_i,
        output credits_empty_i, icache_fence_yumi_i, icache_fence_done_i,
        output redirect_yumi_i,
        input  fence_yumi_o, itlb_flush_v_o, icache_fence_v_o,
        input  redirect_v_o, redirect_pc_o, fetch_block_o, busy_o, timeout_o
    );
endinterface

// File: rtl/bp_fe_fence_sequencer_timer.sv
// Saturating wait-state timer for the fence sequencer.
// expire_o fires on the timeout_p-th enabled cycle since the last clear.
module bp_fe_fence_timer #(
    parameter int timeout_p = 1023
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int w_lp = (timeout_p > 1) ? $clog2(timeout_p + 1) : 1;
    localparam logic [w_lp-1:0] max_lp  = w_lp'(timeout_p);
    localparam logic [w_lp-1:0] last_lp = w_lp'(timeout_p - 1);

    logic [w_lp-1:0] count_q;

    // Count enabled cycles, hold at the limit, restart on clear
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (en_i && (count_q != max_lp)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expire_o = en_i & (count_q == last_lp);
endmodule

// File: rtl/bp_fe_fence_sequencer.sv
// FE fence sequencer: block fetch, drain fills, flush ITLB,
// fence the I$, then redirect pc_gen to the latched npc.
module bp_fe_fence_sequencer
    import bp_fe_pkg::*;
#(
    parameter int vaddr_width_p = 39,
    parameter int timeout_p     = 1023
) (
    input logic                    clk_i,
    input logic                    reset_i,
    bp_fe_fence_sequencer_if.slave io
);
    bp_fe_fence_state_e       state_q;
    logic [vaddr_width_p-1:0] npc_q;
    logic                     itlb_q;
    logic                     icache_q;
    logic                     pending_q;
    logic                     timeout_q;
    logic                     timed;
    logic                     expire;
    logic                     idle;

    assign idle  = (state_q == e_fence_idle);
    assign timed = (state_q == e_fence_drain) | (state_q == e_fence_wait);

    // Only the two wait states count; leaving them restarts the timer
    bp_fe_fence_timer #(
        .timeout_p(timeout_p)
    ) timer (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (~timed),
        .en_i    (timed),
        .expire_o(expire)
    );

    // Sequence one fence command; the awaited event beats a timeout
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= e_fence_idle;
            npc_q     <= '0;
            itlb_q    <= 1'b0;
            icache_q  <= 1'b0;
            pending_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                e_fence_idle: begin
                    if (io.fence_v_i) begin
                        npc_q    <= io.fence_npc_i;
                        itlb_q   <= io.fence_itlb_i;
                        icache_q <= io.fence_icache_i;
                        state_q  <= e_fence_drain;
                    end
                end
                e_fence_drain: begin
                    if (io.credits_empty_i) begin
                        state_q <= fence_after_drain(itlb_q, icache_q);
                    end else if (expire) begin
                        timeout_q <= 1'b1;
                        state_q   <= fence_after_drain(itlb_q, icache_q);
                    end
                end
                e_fence_flush: begin
                    state_q <= icache_q ? e_fence_req : e_fence_resume;
                end
                e_fence_req: begin
                    if (io.icache_fence_yumi_i) begin
                        pending_q <= io.icache_fence_done_i;
                        state_q   <= e_fence_wait;
                    end
                end
                e_fence_wait: begin
                    if (io.icache_fence_done_i || pending_q) begin
                        pending_q <= 1'b0;
                        state_q   <= e_fence_resume;
                    end else if (expire) begin
                        timeout_q <= 1'b1;
                        state_q   <= e_fence_resume;
                    end
                end
                e_fence_resume: begin
                    if (io.redirect_yumi_i) begin
                        state_q <= e_fence_idle;
                    end
                end
                default: state_q <= e_fence_idle;
            endcase
        end
    end

    assign io.fence_yumi_o     = io.fence_v_i & idle & ~reset_i;
    assign io.busy_o           = ~idle;
    assign io.fetch_block_o    = ~idle;
    assign io.itlb_flush_v_o   = (state_q == e_fence_flush);
    assign io.icache_fence_v_o = (state_q == e_fence_req);
    assign io.redirect_v_o     = (state_q == e_fence_resume);
    assign io.redirect_pc_o    = npc_q;
    assign io.timeout_o        = timeout_q;
endmodule

// File: tb/tb_bp_fe_fence_sequencer.sv
// Scoreboard bench for bp_fe_fence_sequencer.
// Responder timing knobs feed an arithmetic latency/timeout model.
module tb_bp_fe_fence_sequencer;
    localparam int VW = 39;
    localparam int T  = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bp_fe_fence_sequencer_if #(.vaddr_width_p(VW)) bus ();

    bp_fe_fence_sequencer #(
        .vaddr_width_p(VW),
        .timeout_p    (T)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .io     (bus)
    );

    typedef struct {
        logic [VW-1:0] pc;
        int            flushes;
        int            fences;
        bit            tmo;
        int            lat;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   sticky;
    bit   hold_chk;
    int   drain_d, yumi_d, done_k, red_d;

    function automatic void chk(string name, longint act, longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void push_cmd(logic [VW-1:0] pc, bit itlb, bit ic);
        exp_t e;
        int   dc, wc, fc;
        bit   tmo;
        dc  = (drain_d + 1 < T) ? drain_d + 1 : T;
        if (done_k == 0) wc = 1;
        else if (done_k < 0 || done_k > T) wc = T;
        else wc = done_k;
        fc  = ic ? (yumi_d + 1) + wc : 0;
        tmo = (drain_d >= T) || (ic && (done_k < 0 || done_k > T));
        sticky    = sticky | tmo;
        e.pc      = pc;
        e.flushes = int'(itlb);
        e.fences  = int'(ic);
        e.tmo     = sticky;
        e.lat     = 1 + dc + int'(itlb) + fc;
        q.push_back(e);
    endfunction

    function automatic void check_reset_outputs(string tag);
        chk({tag, "_busy"}, longint'(bus.busy_o), 0);
        chk({tag, "_fetch_block"}, longint'(bus.fetch_block_o), 0);
        chk({tag, "_fence_yumi"}, longint'(bus.fence_yumi_o), 0);
        chk({tag, "_itlb_flush"}, longint'(bus.itlb_flush_v_o), 0);
        chk({tag, "_icache_fence_v"}, longint'(bus.icache_fence_v_o), 0);
        chk({tag, "_redirect_v"}, longint'(bus.redirect_v_o), 0);
        chk({tag, "_redirect_pc"}, longint'(bus.redirect_pc_o), 0);
        chk({tag, "_timeout"}, longint'(bus.timeout_o), 0);
    endfunction

    // Environment: credits, I$ handshakes and pc_gen yumi from the knobs
    initial begin
        int dcnt, fcnt, wcnt, rcnt;
        bit busy_d;
        dcnt = 100; fcnt = 0; wcnt = -1; rcnt = 0; busy_d = 0;
        bus.credits_empty_i     = 1'b1;
        bus.icache_fence_yumi_i = 1'b0;
        bus.icache_fence_done_i = 1'b0;
        bus.redirect_yumi_i     = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                dcnt = 100; fcnt = 0; wcnt = -1; rcnt = 0; busy_d = 0;
                bus.credits_empty_i     = 1'b1;
                bus.icache_fence_yumi_i = 1'b0;
                bus.icache_fence_done_i = 1'b0;
                bus.redirect_yumi_i     = 1'b0;
                continue;
            end
            if (bus.busy_o && !busy_d) dcnt = 0;
            else if (dcnt < 100) dcnt++;
            busy_d = bus.busy_o;
            bus.credits_empty_i = (dcnt >= drain_d);
            if (bus.icache_fence_v_o) begin
                bus.icache_fence_yumi_i = (fcnt >= yumi_d);
                fcnt++;
            end else begin
                bus.icache_fence_yumi_i = 1'b0;
                fcnt = 0;
            end
            if (bus.icache_fence_yumi_i) wcnt = 0;
            else if (wcnt >= 0 && wcnt < 1000) wcnt++;
            if (!bus.busy_o) wcnt = -1;
            bus.icache_fence_done_i = (wcnt >= 0) && (wcnt == done_k);
            if (bus.redirect_v_o) begin
                bus.redirect_yumi_i = (rcnt >= red_d);
                rcnt++;
            end else begin
                bus.redirect_yumi_i = 1'b0;
                rcnt = 0;
            end
        end
    end

    int acc_cnt, lat, nfl, nfe;
    bit active, prev_rh;

    // Monitor: per-cycle invariants and scoreboard pop on redirect handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            active  = 0;
            prev_rh = 0;
        end else begin
            chk("fetch_block_eq_busy", longint'(bus.fetch_block_o),
                longint'(bus.busy_o));
            if (bus.fence_v_i && bus.busy_o)
                chk("yumi_while_busy", longint'(bus.fence_yumi_o), 0);
            if (bus.fence_yumi_o) begin
                if (hold_chk) begin
                    chk("accept_after_idle", longint'(prev_rh), 1);
                    hold_chk = 0;
                end
                active = 1; acc_cnt = 0; lat = -1; nfl = 0; nfe = 0;
            end else if (active) begin
                acc_cnt++;
            end
            if (bus.itlb_flush_v_o) nfl++;
            if (bus.icache_fence_v_o && bus.icache_fence_yumi_i) nfe++;
            if (bus.redirect_v_o && lat < 0) lat = acc_cnt;
            prev_rh = bus.redirect_v_o && bus.redirect_yumi_i;
            if (prev_rh) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_redirect: got pc %0h want none",
                             bus.redirect_pc_o);
                end else begin
                    e = q.pop_front();
                    chk("redirect_pc", longint'(bus.redirect_pc_o), longint'(e.pc));
                    chk("flush_pulses", longint'(nfl), longint'(e.flushes));
                    chk("fence_handshakes", longint'(nfe), longint'(e.fences));
                    chk("latency", longint'(lat), longint'(e.lat));
                    chk("timeout", longint'(bus.timeout_o), longint'(e.tmo));
                    active = 0;
                end
            end
        end
    end

    task automatic wait_accept();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.fence_yumi_o && n < 400);
        chk("accept_seen", longint'(bus.fence_yumi_o), 1);
    endtask

    task automatic issue(logic [VW-1:0] pc, bit itlb, bit ic);
        push_cmd(pc, itlb, ic);
        @(posedge clk);
        #1;
        bus.fence_v_i      = 1'b1;
        bus.fence_npc_i    = pc;
        bus.fence_itlb_i   = itlb;
        bus.fence_icache_i = ic;
        wait_accept();
        @(posedge clk);
        #1;
        bus.fence_v_i   = 1'b0;
        bus.fence_npc_i = VW'({$urandom(), $urandom()});
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", longint'(q.size()), 0);
        q.delete();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");
        rst    = 1'b0;
        sticky = 0;
    endtask

    task automatic knobs(int d, int y, int k, int r);
        drain_d = d; yumi_d = y; done_k = k; red_d = r;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus.fence_v_i      = 1'b0;
        bus.fence_itlb_i   = 1'b0;
        bus.fence_icache_i = 1'b0;
        bus.fence_npc_i    = '0;
        sticky   = 0;
        hold_chk = 0;
        knobs(0, 0, 1, 0);
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;

        knobs(0, 1, 3, 1);
        issue(39'h80000040, 1, 1);
        wait_done();

        knobs(0, 0, 1, 0);
        issue(39'h1234, 0, 0);
        wait_done();

        knobs(10, 0, 1, 0);
        issue(39'h2000, 1, 0);
        wait_done();

        knobs(T - 1, 0, T, 2);
        issue(39'h3000, 0, 1);
        wait_done();

        knobs(0, 2, 0, 0);
        issue(39'h4000, 1, 1);
        wait_done();

        knobs(0, 0, -1, 0);
        issue(39'h5000, 0, 1);
        wait_done();
        pulse_reset();

        knobs(T + 1, 0, 1, 0);
        issue(39'h6000, 1, 0);
        wait_done();
        pulse_reset();

        knobs(0, 1, 5, 0);
        push_cmd(39'h7000, 0, 1);
        push_cmd(39'h7100, 1, 0);
        @(posedge clk);
        #1;
        bus.fence_v_i      = 1'b1;
        bus.fence_npc_i    = 39'h7000;
        bus.fence_itlb_i   = 1'b0;
        bus.fence_icache_i = 1'b1;
        wait_accept();
        @(posedge clk);
        #1;
        bus.fence_npc_i    = 39'h7100;
        bus.fence_itlb_i   = 1'b1;
        bus.fence_icache_i = 1'b0;
        hold_chk = 1;
        wait_accept();
        @(posedge clk);
        #1;
        bus.fence_v_i = 1'b0;
        wait_done();

        knobs(0, 30, 1, 0);
        issue(39'h7f00, 0, 1);
        n = 0;
        while (!bus.icache_fence_v_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reached_fence_req", longint'(bus.icache_fence_v_o), 1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        sticky = 0;
        @(negedge clk);
        chk("idle_after_reset", longint'(bus.busy_o), 0);

        for (int i = 0; i < 60; i++) begin
            int k;
            if (i % 8 == 7) pulse_reset();
            k = $urandom_range(0, T + 2);
            knobs($urandom_range(0, T + 1), $urandom_range(0, 3),
                  (k == T + 2) ? -1 : k, $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(VW'({$urandom(), $urandom()}), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            wait_done();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
